jtframe_rom_arbiter: RTL and testbench

//  Shares the single game-side SDRAM read port (sdram_req/ack/addr, data_read/data_rdy)

---
 rtl/jtframe_arb_pkg.sv | 15 +
 rtl/jtframe_rom_arbiter_if.sv | 32 +++
 rtl/jtframe_rr_pick.sv | 39 +++
 rtl/jtframe_rom_arbiter.sv | 166 ++++++++++++++++
 tb/tb_jtframe_rom_arbiter.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/jtframe_arb_pkg.sv
// Shared types for the ROM arbiter: FSM state encoding and default bus widths.
package jtframe_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_GAP  = 2'd3
  } arb_state_e;

  localparam int ARB_SLOTS = 4;
  localparam int ARB_AW    = 22;
  localparam int ARB_DW    = 32;

endpackage

// File: rtl/jtframe_rom_arbiter_if.sv
// ROM-slot and SDRAM-read signal bundle. The arbiter uses the master modport;
// the ROM fetchers and the SDRAM controller side use the slave modport.
interface jtframe_rom_arbiter_if
  import jtframe_arb_pkg::*;
#(
  parameter int SLOTS = ARB_SLOTS,
  parameter int AW    = ARB_AW,
  parameter int DW    = ARB_DW
);

  logic [SLOTS-1:0]    slot_req;
  logic [SLOTS*AW-1:0] slot_addr;
  logic [SLOTS-1:0]    slot_ack;
  logic [SLOTS-1:0]    slot_ok;
  logic [SLOTS*DW-1:0] slot_dout;
  logic                sdram_req;
  logic [AW-1:0]       sdram_addr;
  logic                sdram_ack;
  logic [DW-1:0]       data_read;
  logic                data_rdy;

  modport master (
    input  slot_req, slot_addr, sdram_ack, data_read, data_rdy,
    output slot_ack, slot_ok, slot_dout, sdram_req, sdram_addr
  );

  modport slave (
    output slot_req, slot_addr, sdram_ack, data_read, data_rdy,
    input  slot_ack, slot_ok, slot_dout, sdram_req, sdram_addr
  );

endinterface

// File: rtl/jtframe_rr_pick.sv
// Combinational round-robin picker: first set bit of req_i at or after ptr_i,
// wrapping modulo N.
module jtframe_rr_pick #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic          any_o,
  output logic [PW-1:0] idx_o
);

  logic [PW:0]   sum_s;
  logic [PW-1:0] cand_s;

  // scan N candidates starting at ptr_i; the first requester found wins
  always_comb begin
    any_o  = 1'b0;
    idx_o  = '0;
    sum_s  = '0;
    cand_s = '0;
    for (int k = 0; k < N; k++) begin
      sum_s = {1'b0, ptr_i} + (PW+1)'(k);
      if (sum_s >= (PW+1)'(N)) begin
        sum_s = sum_s - (PW+1)'(N);
      end else begin
        sum_s = sum_s;
      end
      cand_s = sum_s[PW-1:0];
      if (!any_o && req_i[cand_s]) begin
        any_o = 1'b1;
        idx_o = cand_s;
      end else begin
        any_o = any_o;
      end
    end
  end

endmodule

// File: rtl/jtframe_rom_arbiter.sv
// Round-robin arbiter sharing one SDRAM read port among SLOTS ROM requesters.
// Optional per-slot one-word cache enabled by defining JTFRAME_ARB_CACHE_EN.
module jtframe_rom_arbiter
  import jtframe_arb_pkg::*;
#(
  parameter int SLOTS = ARB_SLOTS,
  parameter int AW    = ARB_AW,
  parameter int DW    = ARB_DW
) (
  input  logic                  clk_rom,
  input  logic                  rst_n,
  input  logic                  downloading,
  input  logic                  loop_rst,
  jtframe_rom_arbiter_if.master bus
);

  localparam int PW = (SLOTS > 1) ? $clog2(SLOTS) : 1;

  arb_state_e       state_q, state_d;
  logic [PW-1:0]    sel_q, sel_d, ptr_q, ptr_d, pick_idx_s;
  logic             pick_any_s;
  logic             req_q, req_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [SLOTS-1:0] ack_q, ack_d, ok_q, ok_d, hit_s, elig_s;
  logic [AW-1:0]    addr_s [SLOTS];
  logic [DW-1:0]    dout_q [SLOTS];
  logic             abort_s, fill_s;

  assign abort_s = downloading | loop_rst;
  assign fill_s  = (state_q == ST_WAIT) && !abort_s && bus.data_rdy;

  always_comb begin
    for (int i = 0; i < SLOTS; i++) begin
      addr_s[i] = bus.slot_addr[i*AW +: AW];
    end
  end

`ifdef JTFRAME_ARB_CACHE_EN
  logic [SLOTS-1:0] valid_q;
  logic [AW-1:0]    tag_q [SLOTS];

  // a slot whose ok is already pulsing is still holding req; do not hit it twice
  always_comb begin
    for (int i = 0; i < SLOTS; i++) begin
      hit_s[i] = bus.slot_req[i] & valid_q[i] & ~ok_q[i] & ~abort_s
                 & (addr_s[i] == tag_q[i]);
    end
  end

  always_ff @(posedge clk_rom or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < SLOTS; i++) tag_q[i] <= '0;
    end else if (abort_s) begin
      valid_q <= '0;
    end else if (fill_s) begin
      valid_q[sel_q] <= 1'b1;
      tag_q[sel_q]   <= addr_q;
    end else begin
      valid_q <= valid_q;
    end
  end
`else
  assign hit_s = '0;
`endif

  assign elig_s = bus.slot_req & ~hit_s & ~ok_q;

  jtframe_rr_pick #(.N(SLOTS), .PW(PW)) u_pick (
    .req_i (elig_s),
    .ptr_i (ptr_q),
    .any_o (pick_any_s),
    .idx_o (pick_idx_s)
  );

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    req_d   = req_q;
    addr_d  = addr_q;
    ack_d   = '0;
    ok_d    = hit_s;
    if (abort_s) begin
      state_d = ST_IDLE;
      req_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pick_any_s) begin
            sel_d   = pick_idx_s;
            addr_d  = addr_s[pick_idx_s];
            req_d   = 1'b1;
            state_d = ST_REQ;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_REQ: begin
          if (bus.sdram_ack) begin
            req_d        = 1'b0;
            ack_d[sel_q] = 1'b1;
            ptr_d        = (sel_q == PW'(SLOTS-1)) ? '0 : sel_q + PW'(1);
            state_d      = ST_WAIT;
          end else begin
            state_d = ST_REQ;
          end
        end
        ST_WAIT: begin
          if (fill_s) begin
            ok_d[sel_q] = 1'b1;
            state_d     = ST_GAP;
          end else begin
            state_d = ST_WAIT;
          end
        end
        ST_GAP:  state_d = ST_IDLE;
        default: begin
          state_d = ST_IDLE;
          req_d   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_rom or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      ptr_q   <= '0;
      req_q   <= 1'b0;
      addr_q  <= '0;
      ack_q   <= '0;
      ok_q    <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      ack_q   <= ack_d;
      ok_q    <= ok_d;
    end
  end

  // per-slot read data only changes on a completed SDRAM fill
  always_ff @(posedge clk_rom or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SLOTS; i++) dout_q[i] <= '0;
    end else if (fill_s) begin
      dout_q[sel_q] <= bus.data_read;
    end else begin
      dout_q[sel_q] <= dout_q[sel_q];
    end
  end

  assign bus.sdram_req  = req_q;
  assign bus.sdram_addr = addr_q;
  assign bus.slot_ack   = ack_q;
  assign bus.slot_ok    = ok_q;

  for (genvar g = 0; g < SLOTS; g++) begin : g_dout
    assign bus.slot_dout[g*DW +: DW] = dout_q[g];
  end

endmodule

// File: tb/tb_jtframe_rom_arbiter.sv
// Directed bench for jtframe_rom_arbiter; cache checks run when JTFRAME_ARB_CACHE_EN is defined.
module tb_jtframe_rom_arbiter;

  localparam int AW = 22;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n;
  logic downloading;
  logic loop_rst;
  int   vec_cnt = 0;
  int   err_cnt = 0;

  jtframe_rom_arbiter_if #(.SLOTS(4), .AW(AW), .DW(DW)) bus ();

  jtframe_rom_arbiter #(.SLOTS(4), .AW(AW), .DW(DW)) dut (
    .clk_rom     (clk),
    .rst_n       (rst_n),
    .downloading (downloading),
    .loop_rst    (loop_rst),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] dout_of(input int s);
    return bus.slot_dout[s*DW +: DW];
  endfunction

  task automatic do_reset();
    rst_n         = 1'b0;
    downloading   = 1'b0;
    loop_rst      = 1'b0;
    bus.slot_req  = '0;
    bus.slot_addr = '0;
    bus.sdram_ack = 1'b0;
    bus.data_read = '0;
    bus.data_rdy  = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic set_req(input int s, input logic [AW-1:0] a);
    bus.slot_addr[s*AW +: AW] = a;
    bus.slot_req[s] = 1'b1;
  endtask

  // one complete access: ack one cycle after req seen, data three cycles after ack
  task automatic serve(input string tag, input int s, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n = 0;
    while (!bus.sdram_req && n < 20) begin
      tick();
      n++;
    end
    check_val({tag, "_req"}, 64'(bus.sdram_req), 64'd1);
    check_val({tag, "_addr"}, 64'(bus.sdram_addr), 64'(a));
    tick();
    bus.sdram_ack = 1'b1;
    tick();
    bus.sdram_ack = 1'b0;
    check_val({tag, "_ack"}, 64'(bus.slot_ack), 64'(4'b0001 << s));
    check_val({tag, "_reqlow"}, 64'(bus.sdram_req), 64'd0);
    tick();
    tick();
    bus.data_read = d;
    bus.data_rdy  = 1'b1;
    tick();
    bus.data_rdy  = 1'b0;
    check_val({tag, "_ok"}, 64'(bus.slot_ok), 64'(4'b0001 << s));
    check_val({tag, "_dout"}, 64'(dout_of(s)), 64'(d));
    tick();
    check_val({tag, "_okclr"}, 64'(bus.slot_ok), 64'd0);
    bus.slot_req[s] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n         = 1'b0;
    downloading   = 1'b0;
    loop_rst      = 1'b0;
    bus.slot_req  = '0;
    bus.slot_addr = '0;
    bus.sdram_ack = 1'b0;
    bus.data_read = '0;
    bus.data_rdy  = 1'b0;
    #3;
    check_val("rst_req", 64'(bus.sdram_req), 64'd0);
    check_val("rst_addr", 64'(bus.sdram_addr), 64'd0);
    check_val("rst_ack", 64'(bus.slot_ack), 64'd0);
    check_val("rst_ok", 64'(bus.slot_ok), 64'd0);
    check_val("rst_dout", 64'(bus.slot_dout[63:0]), 64'd0);

    // 1: single access on slot 2 with exact cycle timing
    do_reset();
    set_req(2, 22'h001234);
    tick();
    check_val("t1_req", 64'(bus.sdram_req), 64'd1);
    check_val("t1_addr", 64'(bus.sdram_addr), 64'h1234);
    tick();
    check_val("t1_hold", 64'(bus.sdram_req), 64'd1);
    bus.sdram_ack = 1'b1;
    tick();
    bus.sdram_ack = 1'b0;
    check_val("t1_ack", 64'(bus.slot_ack), 64'h4);
    check_val("t1_reqlow", 64'(bus.sdram_req), 64'd0);
    tick();
    check_val("t1_ack1shot", 64'(bus.slot_ack), 64'd0);
    repeat (3) tick();
    check_val("t1_noearly", 64'(bus.slot_ok), 64'd0);
    bus.data_read = 32'hCAFEBABE;
    bus.data_rdy  = 1'b1;
    tick();
    bus.data_rdy  = 1'b0;
    check_val("t1_ok", 64'(bus.slot_ok), 64'h4);
    check_val("t1_dout", 64'(dout_of(2)), 64'hCAFEBABE);
    tick();
    check_val("t1_ok1shot", 64'(bus.slot_ok), 64'd0);
    bus.slot_req[2] = 1'b0;
    tick();

    // 6: stray data_rdy and sdram_ack while idle are ignored
    bus.data_read = 32'hDEADBEEF;
    bus.data_rdy  = 1'b1;
    bus.sdram_ack = 1'b1;
    tick();
    bus.data_rdy  = 1'b0;
    bus.sdram_ack = 1'b0;
    tick();
    check_val("t6_ok", 64'(bus.slot_ok), 64'd0);
    check_val("t6_ack", 64'(bus.slot_ack), 64'd0);
    check_val("t6_dout", 64'(dout_of(2)), 64'hCAFEBABE);
    check_val("t6_req", 64'(bus.sdram_req), 64'd0);

    // 2: all four request at once, then slot 0 asks again
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, 22'(32'h100 + i));
    serve("t2_s0", 0, 22'h100, 32'hA0A0_0000);
    tick();
    set_req(0, 22'h200);
    serve("t2_s1", 1, 22'h101, 32'hA1A1_1111);
    serve("t2_s2", 2, 22'h102, 32'hA2A2_2222);
    serve("t2_s3", 3, 22'h103, 32'hA3A3_3333);
    serve("t2_s0b", 0, 22'h200, 32'hA0A0_BBBB);
    check_val("t2_dout1", 64'(dout_of(1)), 64'hA1A1_1111);

    // 3: loop_rst during WAIT aborts slot 1, which is re-issued afterwards
    do_reset();
    set_req(1, 22'h0555);
    tick();
    check_val("t3_req", 64'(bus.sdram_req), 64'd1);
    bus.sdram_ack = 1'b1;
    tick();
    bus.sdram_ack = 1'b0;
    check_val("t3_ack", 64'(bus.slot_ack), 64'h2);
    tick();
    loop_rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.data_read = 32'h5555_AAAA;
      bus.data_rdy  = (i == 1);
      tick();
      check_val("t3_reqlow", 64'(bus.sdram_req), 64'd0);
      check_val("t3_nook", 64'(bus.slot_ok), 64'd0);
    end
    bus.data_rdy = 1'b0;
    check_val("t3_doutkeep", 64'(dout_of(1)), 64'd0);
    loop_rst = 1'b0;
    serve("t3_retry", 1, 22'h0555, 32'h1357_9BDF);

    // 4: downloading blocks every grant; slot 0 wins afterwards
    do_reset();
    downloading = 1'b1;
    for (int i = 0; i < 4; i++) set_req(i, 22'(32'h300 + i));
    for (int i = 0; i < 4; i++) begin
      tick();
      check_val("t4_req", 64'(bus.sdram_req), 64'd0);
      check_val("t4_ackok", 64'({bus.slot_ack, bus.slot_ok}), 64'd0);
    end
    check_val("t4_dout", 64'(bus.slot_dout[63:0]), 64'd0);
    downloading = 1'b0;
    serve("t4_s0", 0, 22'h300, 32'h0BAD_F00D);

`ifdef JTFRAME_ARB_CACHE_EN
    // 5: second read of the same address is a hit; downloading invalidates it
    do_reset();
    set_req(3, 22'h0040);
    serve("t5_fill", 3, 22'h0040, 32'h1111_2222);
    tick();
    set_req(3, 22'h0040);
    tick();
    check_val("t5_hitok", 64'(bus.slot_ok), 64'h8);
    check_val("t5_hitreq", 64'(bus.sdram_req), 64'd0);
    check_val("t5_hitdout", 64'(dout_of(3)), 64'h1111_2222);
    tick();
    check_val("t5_hit1shot", 64'(bus.slot_ok), 64'd0);
    bus.slot_req[3] = 1'b0;
    tick();
    check_val("t5_nosdram", 64'(bus.sdram_req), 64'd0);
    downloading = 1'b1;
    tick();
    downloading = 1'b0;
    tick();
    set_req(3, 22'h0040);
    tick();
    check_val("t5_miss_ok", 64'(bus.slot_ok), 64'd0);
    serve("t5_refill", 3, 22'h0040, 32'h3333_4444);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
